fetch_pc_fifo: RTL and testbench

- Decoupling buffer directly downstream of the next-PC generator.
- Captures each fetch PC together with its predicted next PC and holds them in order.
- Presents them to the instruction-cache request stage.
- Back-pressures the PC generator through ready_o, which drives the generator's stall input.
- A redirect flush discards all buffered, now wrong-path, entries.

---
 rtl/fetch_pc_fifo_pkg.sv | 27 ++
 rtl/fetch_pc_fifo.sv | 132 +++++++++++++
 tb/tb_fetch_pc_fifo.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_fifo_pkg.sv
// Shared types for the fetch-PC decoupling buffer.
// Holds the entry layout that travels between the next-PC generator and the
// instruction-cache request stage, plus the architectural fetch reset vector.
package fetch_pc_fifo_pkg;

  // One fetch slot: the PC being fetched and the PC predicted to follow it.
  // They are packed together so they can never be separated in storage.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc_pred;
  } fetch_pc_entry_t;

  // Architectural fetch reset vector; handy as a base address in benches.
  localparam logic [31:0] FETCH_PC_RESET = 32'h1c00_0000;

  // Build an entry from its two halves.
  function automatic fetch_pc_entry_t fetch_pc_entry_pack(
    input logic [31:0] pc,
    input logic [31:0] npc_pred
  );
    fetch_pc_entry_t e;
    e.pc       = pc;
    e.npc_pred = npc_pred;
    return e;
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// fetch_pc_fifo: in-order buffer between the next-PC generator and the
// I-cache request stage. ready_o back-pressures the generator (its inverse is
// the generator's stall), and flush_i drops every wrong-path entry at once.
//
// Build option: define FETCH_PC_FIFO_BYPASS_EN to let an incoming PC pass
// straight to the outputs in the same cycle while the buffer is empty. When
// it is left undefined the minimum latency is one cycle and no input reaches
// valid_o, pc_o or npc_pred_o combinationally.
module fetch_pc_fifo
  import fetch_pc_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] npc_pred_i,
  output logic        ready_o,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_pred_o,
  input  logic        ready_i
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg,  count_next;

  fetch_pc_entry_t  mem_reg [DEPTH];
  fetch_pc_entry_t  in_entry;
  fetch_pc_entry_t  head_entry;
  fetch_pc_entry_t  out_entry;

  logic             stored_valid;
  logic             push;
  logic             pop;
  logic             bypass_take;
  logic             wr_en;
  logic             rd_en;
  logic [DEPTH-1:0] wr_sel;

  assign in_entry     = fetch_pc_entry_pack(pc_i, npc_pred_i);
  assign head_entry   = mem_reg[rd_ptr_reg];
  assign stored_valid = (count_reg != '0);

  // Space check looks only at the occupancy, never at ready_i, so a full
  // buffer stalls the generator even in a cycle where the head drains.
  assign ready_o = (count_reg != FULL_COUNT);

`ifdef FETCH_PC_FIFO_BYPASS_EN
  logic bypass_active;

  // Empty buffer with a live request: show the request itself at the output.
  assign bypass_active = ~stored_valid & valid_i & ~flush_i;
  assign valid_o       = stored_valid | bypass_active;
  assign out_entry     = stored_valid ? head_entry : in_entry;
  // Consumed on the spot: it is neither written nor read from storage.
  assign bypass_take   = bypass_active & ready_i;
`else
  assign valid_o       = stored_valid;
  assign out_entry     = head_entry;
  assign bypass_take   = 1'b0;
`endif

  // Zero the data outputs when nothing valid is presented so the request
  // stage never sees stale PCs from retired slots.
  assign pc_o       = valid_o ? out_entry.pc       : '0;
  assign npc_pred_o = valid_o ? out_entry.npc_pred : '0;

  assign push  = valid_i & ready_o & ~flush_i;
  assign pop   = valid_o & ready_i & ~flush_i;
  assign wr_en = push & ~bypass_take;
  assign rd_en = pop  & ~bypass_take;

  // One-hot write select for the storage slot addressed by the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (wr_ptr_reg == PTR_W'(gi));
  end

  // Next-state for pointers and occupancy; flush empties the buffer and
  // overrides any handshake seen in the same cycle.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
        2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state: asynchronous reset restarts the buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage: contents need no reset because occupancy gates the outputs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem_reg[i] <= in_entry;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_fifo.sv
// Bench for fetch_pc_fifo: scenario tasks driven against a queue-based model.
module tb_fetch_pc_fifo;
  import fetch_pc_fifo_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_PC_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] npc_pred_i = '0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] npc_pred_o;
  logic        ready_i = 1'b0;

  int errors = 0;
  int checks = 0;

  fetch_pc_entry_t model_q[$];

  fetch_pc_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .pc_i       (pc_i),
    .npc_pred_i (npc_pred_i),
    .ready_o    (ready_o),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .npc_pred_o (npc_pred_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  // Model view of the outputs for the current inputs.
  function automatic bit m_bypass();
    return BYP && (model_q.size() == 0) && valid_i && !flush_i && rst_n;
  endfunction

  function automatic bit m_valid();
    return (model_q.size() != 0) || m_bypass();
  endfunction

  function automatic bit m_ready();
    return model_q.size() != DEPTH;
  endfunction

  function automatic logic [31:0] m_pc();
    if (model_q.size() != 0) return model_q[0].pc;
    if (m_bypass()) return pc_i;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_npc();
    if (model_q.size() != 0) return model_q[0].npc_pred;
    if (m_bypass()) return npc_pred_i;
    return 32'h0;
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] npc,
                       input bit r, input bit f);
    valid_i    = v;
    pc_i       = pc;
    npc_pred_i = npc;
    ready_i    = r;
    flush_i    = f;
  endtask

  // Advance one clock edge and apply the same transfer rules to the model.
  task automatic tick();
    bit v, r, f, ev, byp, full;
    fetch_pc_entry_t e;
    v    = valid_i;
    r    = ready_i;
    f    = flush_i;
    ev   = m_valid();
    byp  = m_bypass() && r;
    full = !m_ready();
    e.pc       = pc_i;
    e.npc_pred = npc_pred_i;
    @(posedge clk);
    if (!rst_n || f) begin
      model_q.delete();
    end else if (byp) begin
      $display("xfer bypass pc=%h npc=%h", e.pc, e.npc_pred);
    end else begin
      if (ev && r) begin
        $display("xfer pop    pc=%h npc=%h", model_q[0].pc, model_q[0].npc_pred);
        void'(model_q.pop_front());
      end
      if (v && !full) begin
        $display("xfer push   pc=%h npc=%h", e.pc, e.npc_pred);
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 32'h0, 32'h0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", pc_o); end
    checks++; if (npc_pred_o !== 32'h0) begin errors++; $display("FAIL reset_npc got=%h want=0", npc_pred_o); end
    rst_n = 1'b1;
    model_q.delete();
    @(negedge clk);
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_release got valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] npcs [4];
    for (int k = 0; k < 4; k++) begin
      npcs[k] = $urandom;
      drive(1, FETCH_PC_RESET + 32'(4 * k), npcs[k], 0, 0);
      @(negedge clk);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b want=1", k, ready_o); end
      tick();
    end
    drive(1, FETCH_PC_RESET + 32'h10, 32'hdead_beef, 0, 0);
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b want=0", ready_o); end
    checks++; if (valid_o !== 1'b1 || pc_o !== FETCH_PC_RESET) begin
      errors++; $display("FAIL fill_head got valid=%b pc=%h want valid=1 pc=%h", valid_o, pc_o, FETCH_PC_RESET);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      checks++; if (valid_o !== 1'b1 || pc_o !== FETCH_PC_RESET + 32'(4 * k)) begin
        errors++; $display("FAIL drain_pc[%0d] got valid=%b pc=%h want pc=%h", k, valid_o, pc_o, FETCH_PC_RESET + 32'(4 * k));
      end
      checks++; if (npc_pred_o !== npcs[k]) begin
        errors++; $display("FAIL drain_npc[%0d] got=%h want=%h", k, npc_pred_o, npcs[k]);
      end
      if (k > 0) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready[%0d] got=%b want=1", k, ready_o); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fill_dropped got valid=%b pc=%h want valid=0", valid_o, pc_o); end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] want;
    for (int k = 0; k < 20; k++) begin
      drive(1, FETCH_PC_RESET + 32'(4 * k), FETCH_PC_RESET + 32'(4 * k + 4), 1, 0);
      @(negedge clk);
      if (BYP) want = FETCH_PC_RESET + 32'(4 * k);
      else     want = FETCH_PC_RESET + 32'(4 * (k - 1));
      if (BYP || k > 0) begin
        checks++; if (valid_o !== 1'b1 || pc_o !== want || npc_pred_o !== want + 32'h4) begin
          errors++; $display("FAIL stream[%0d] got valid=%b pc=%h npc=%h want pc=%h npc=%h", k, valid_o, pc_o, npc_pred_o, want, want + 32'h4);
        end
      end else begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_first got valid=%b want=0", valid_o); end
      end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b want=1", k, ready_o); end
      tick();
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if (valid_o !== !BYP || pc_o !== (BYP ? 32'h0 : FETCH_PC_RESET + 32'd76)) begin
      errors++; $display("FAIL stream_tail got valid=%b pc=%h want valid=%b", valid_o, pc_o, !BYP);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1, FETCH_PC_RESET + 32'h40 + 32'(4 * k), $urandom, 0, 0);
      tick();
    end
    drive(1, FETCH_PC_RESET + 32'h100, 32'h1234_5678, 1, 1);
    @(negedge clk);
    checks++; if (valid_o !== 1'b1 || pc_o !== FETCH_PC_RESET + 32'h40) begin
      errors++; $display("FAIL flush_pre got valid=%b pc=%h want pc=%h", valid_o, pc_o, FETCH_PC_RESET + 32'h40);
    end
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || pc_o !== 32'h0) begin
      errors++; $display("FAIL flush_post got valid=%b ready=%b pc=%h want valid=0 ready=1 pc=0", valid_o, ready_o, pc_o);
    end
    tick();
    drive(1, FETCH_PC_RESET + 32'h200, 32'h1c00_0204, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b1 || pc_o !== FETCH_PC_RESET + 32'h200 || npc_pred_o !== 32'h1c00_0204) begin
      errors++; $display("FAIL flush_first got valid=%b pc=%h npc=%h want pc=%h", valid_o, pc_o, npc_pred_o, FETCH_PC_RESET + 32'h200);
    end
    tick();
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty got valid=%b want=0", valid_o); end
    tick();
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    bit v, r;
    logic [31:0] base;
    base = FETCH_PC_RESET + 32'h1000;
    while (popped < 11 && cyc < 400) begin
      v = (pushed < 11) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, base + 32'(4 * pushed), $urandom, r, 0);
      @(negedge clk);
      checks++; if (valid_o !== m_valid() || ready_o !== m_ready()) begin
        errors++; $display("FAIL wrap_ctl[%0d] got valid=%b ready=%b want valid=%b ready=%b", cyc, valid_o, ready_o, m_valid(), m_ready());
      end
      checks++; if (pc_o !== m_pc() || npc_pred_o !== m_npc()) begin
        errors++; $display("FAIL wrap_data[%0d] got pc=%h npc=%h want pc=%h npc=%h", cyc, pc_o, npc_pred_o, m_pc(), m_npc());
      end
      if (m_valid() && r) begin
        checks++; if (pc_o !== base + 32'(4 * popped)) begin
          errors++; $display("FAIL wrap_order[%0d] got pc=%h want pc=%h", popped, pc_o, base + 32'(4 * popped));
        end
        popped++;
      end
      if (v && m_ready()) pushed++;
      tick();
      cyc++;
    end
    checks++; if (popped != 11) begin errors++; $display("FAIL wrap_timeout got popped=%0d want=11", popped); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1, FETCH_PC_RESET + 32'h300 + 32'(4 * k), $urandom, 0, 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b1 || pc_o !== FETCH_PC_RESET + 32'h300) begin
      errors++; $display("FAIL midrst_pre got valid=%b pc=%h want pc=%h", valid_o, pc_o, FETCH_PC_RESET + 32'h300);
    end
    #1 rst_n = 1'b0;
    flush_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || pc_o !== 32'h0 || npc_pred_o !== 32'h0) begin
      errors++; $display("FAIL midrst_async got valid=%b ready=%b pc=%h npc=%h want 0/1/0/0", valid_o, ready_o, pc_o, npc_pred_o);
    end
    tick();
    rst_n   = 1'b1;
    flush_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || pc_o !== 32'h0) begin
        errors++; $display("FAIL midrst_empty[%0d] got valid=%b ready=%b pc=%h", k, valid_o, ready_o, pc_o);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
